// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings, divisor helper.
// Latency and backpressure: not applicable (types and constants only).
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int DEFAULT_CLK_FREQ   = 50_000_000;
  localparam int DEFAULT_BAUD       = 9600;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_divisor(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Free-running oversample strobe: one-clock pulse every DIVISOR clocks.
// Latency: first pulse DIVISOR clocks after reset release; no backpressure.
module uart_baud_tick_gen #(
  parameter int DIVISOR = 326
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling; byte delivered with a one-clock rx_done strobe.
// Latency: ~9.5 bit periods from start edge; no backpressure, consumer must take each byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 frame_err,
  output logic                 baud_tick
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int NW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [3:0]    S_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    S_STOP = 4'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rxs;
  uart_state_t          state;
  logic [3:0]           s;
  logic [NW-1:0]        n;
  logic [DATA_BITS-1:0] sreg;

  uart_baud_tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .tick (baud_tick)
  );

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      sreg      <= '0;
      d_out     <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (baud_tick) begin
            if (s == S_MID) begin
              if (!rxs) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (s == S_LAST) begin
              s    <= '0;
              sreg <= {rxs, sreg[DATA_BITS-1:1]};
              if (n == N_LAST) begin
                state <= STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (s == S_STOP) begin
              d_out     <= sreg;
              frame_err <= ~rxs;
              rx_done   <= 1'b1;
              state     <= IDLE;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: fast-divisor instance for framing, default instance for tick period.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 20_000;
  localparam int TICK     = 5;                // 1.6e6 / (20000*16)
  localparam int BIT      = 16 * TICK;
  localparam int DEF_DIV  = 326;
  localparam int LAT_NOM  = 19 * BIT / 2;     // 9.5 bit periods
  localparam int LAT_MIN  = LAT_NOM - TICK;
  localparam int LAT_MAX  = LAT_NOM + TICK + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       rx_done, frame_err, baud_tick;
  logic [7:0] d_out;
  logic       def_done, def_ferr, def_tick;
  logic [7:0] def_dout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    int         t;
  } ev_t;

  ev_t  got_q[$];
  int   dbl_cnt   = 0;
  logic prev_done = 1'b0;
  logic [7:0] last_byte = 8'h00;

  always #5 clock = ~clock;

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_dut (
    .clock(clock), .reset(reset), .rx(rx),
    .rx_done(rx_done), .d_out(d_out), .frame_err(frame_err), .baud_tick(baud_tick)
  );

  uart_receiver u_def (
    .clock(clock), .reset(reset), .rx(1'b1),
    .rx_done(def_done), .d_out(def_dout), .frame_err(def_ferr), .baud_tick(def_tick)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    ev_t e;
    if (rx_done) begin
      e.d  = d_out;
      e.fe = frame_err;
      e.t  = cyc;
      got_q.push_back(e);
      if (prev_done) dbl_cnt++;
    end
    prev_done = rx_done;
  end

  task automatic drive(input logic b, input int nclk);
    rx = b;
    repeat (nclk) @(posedge clock);
    #1;
  endtask

  // Stop bit 0 is held just past its mid-point so the line is high again before the next sample.
  task automatic send_frame(input logic [7:0] data, input logic stop_ok, output int t_edge);
    t_edge = cyc;
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(data[i], BIT);
    if (stop_ok) begin
      drive(1'b1, BIT);
    end else begin
      drive(1'b0, 11 * TICK);
      drive(1'b1, 5 * TICK);
    end
  endtask

  task automatic wait_done(input int budget, output logic ok, output ev_t e);
    for (int i = 0; i < budget && got_q.size() == 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (got_q.size() == 0) begin
      ok = 1'b0; e.d = 8'h00; e.fe = 1'b0; e.t = 0;
    end else begin
      ok = 1'b1; e = got_q.pop_front();
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({rx_done, d_out, frame_err, baud_tick} !== 11'b0)
      $display("FAIL reset_outputs got done=%b d=%h fe=%b tick=%b want all 0", rx_done, d_out, frame_err, baud_tick);
    checks++;
    if ({def_done, def_dout, def_ferr, def_tick} !== 11'b0)
      $display("FAIL reset_def_outputs got done=%b d=%h fe=%b tick=%b want all 0", def_done, def_dout, def_ferr, def_tick);
    checks++;
    if (u_dut.state !== IDLE) $display("FAIL reset_state got %0d want IDLE", u_dut.state);
    failures += ((({rx_done, d_out, frame_err, baud_tick} !== 11'b0) ? 1 : 0)
               + (({def_done, def_dout, def_ferr, def_tick} !== 11'b0) ? 1 : 0)
               + ((u_dut.state !== IDLE) ? 1 : 0));
    reset = 1'b1;
  endtask

  task automatic test_tick_period;
    int tt[4];
    int n = 0, wide = 0, ft[3], fn = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 5 * DEF_DIV && n < 4; i++) begin
      @(negedge clock);
      if (def_tick && prev) wide++;
      if (def_tick) begin tt[n] = cyc; n++; end
      if (baud_tick && fn < 3) begin ft[fn] = cyc; fn++; end
      prev = def_tick;
    end
    @(negedge clock);
    if (def_tick && prev) wide++;
    checks++;
    if (n != 4) begin failures++; $display("FAIL tick_count got %0d want 4 pulses", n); end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (n == 4 && tt[k] - tt[k-1] != DEF_DIV) begin
        failures++; $display("FAIL tick_period got %0d want %0d", tt[k] - tt[k-1], DEF_DIV);
      end
    end
    checks++;
    if (wide != 0) begin failures++; $display("FAIL tick_width got %0d wide pulses want 0", wide); end
    checks++;
    if (fn != 3 || ft[2] - ft[1] != TICK || ft[1] - ft[0] != TICK) begin
      failures++; $display("FAIL fast_tick_period got n=%0d d=%0d want %0d", fn, ft[1] - ft[0], TICK);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_nominal;
    int t0; logic ok; ev_t e;
    drive(1'b1, BIT);
    send_frame(8'h57, 1'b1, t0);
    wait_done(100, ok, e);
    checks++;
    if (!ok || e.d !== 8'h57 || e.fe !== 1'b0) begin
      failures++; $display("FAIL nominal_byte got ok=%b d=%h fe=%b want d=57 fe=0", ok, e.d, e.fe);
    end
    checks++;
    if (ok && (e.t - t0 < LAT_MIN || e.t - t0 > LAT_MAX)) begin
      failures++; $display("FAIL nominal_latency got %0d want %0d..%0d", e.t - t0, LAT_MIN, LAT_MAX);
    end
    drive(1'b1, 2 * BIT);
    checks++;
    if (d_out !== 8'h57 || frame_err !== 1'b0 || got_q.size() != 0) begin
      failures++; $display("FAIL nominal_hold got d=%h fe=%b extra=%0d want d=57 fe=0 extra=0", d_out, frame_err, got_q.size());
    end
    last_byte = 8'h57;
  endtask

  task automatic test_back_to_back;
    int t0, t1; logic ok0, ok1; ev_t e0, e1;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    wait_done(100, ok0, e0);
    wait_done(100, ok1, e1);
    checks++;
    if (!ok0 || !ok1 || e0.d !== 8'h00 || e1.d !== 8'hFF || e0.fe !== 1'b0 || e1.fe !== 1'b0) begin
      failures++; $display("FAIL b2b_bytes got ok=%b%b d=%h,%h want 00,FF", ok0, ok1, e0.d, e1.d);
    end
    checks++;
    if (ok0 && ok1 && (e1.t - e0.t < 10 * BIT - 13 || e1.t - e0.t > 10 * BIT + 13)) begin
      failures++; $display("FAIL b2b_spacing got %0d want %0d +-13", e1.t - e0.t, 10 * BIT);
    end
    last_byte = 8'hFF;
  endtask

  task automatic test_glitch;
    int t0; logic ok; ev_t e;
    drive(1'b0, 4 * TICK);
    drive(1'b1, 2 * BIT);
    checks++;
    if (got_q.size() != 0 || d_out !== last_byte || u_dut.state !== IDLE) begin
      failures++; $display("FAIL glitch_reject got pulses=%0d d=%h state=%0d want 0,%h,IDLE", got_q.size(), d_out, u_dut.state, last_byte);
    end
    send_frame(8'hA5, 1'b1, t0);
    wait_done(100, ok, e);
    checks++;
    if (!ok || e.d !== 8'hA5 || e.fe !== 1'b0) begin
      failures++; $display("FAIL glitch_next got ok=%b d=%h fe=%b want A5 fe=0", ok, e.d, e.fe);
    end
    last_byte = 8'hA5;
  endtask

  task automatic test_frame_err;
    int t0; logic ok; ev_t e;
    send_frame(8'h3C, 1'b0, t0);
    wait_done(100, ok, e);
    checks++;
    if (!ok || e.d !== 8'h3C || e.fe !== 1'b1) begin
      failures++; $display("FAIL ferr_byte got ok=%b d=%h fe=%b want 3C fe=1", ok, e.d, e.fe);
    end
    drive(1'b1, 2 * BIT);
    checks++;
    if (got_q.size() != 0 || frame_err !== 1'b1) begin
      failures++; $display("FAIL ferr_hold got extra=%0d fe=%b want 0,1", got_q.size(), frame_err);
    end
    send_frame(8'hC3, 1'b1, t0);
    wait_done(100, ok, e);
    checks++;
    if (!ok || e.d !== 8'hC3 || e.fe !== 1'b0) begin
      failures++; $display("FAIL ferr_clear got ok=%b d=%h fe=%b want C3 fe=0", ok, e.d, e.fe);
    end
    last_byte = 8'hC3;
  endtask

  task automatic test_reset_mid;
    int t0; logic ok; ev_t e;
    logic [7:0] data = 8'h6B;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(data[i], BIT);
    drive(data[4], BIT / 2);
    reset = 1'b0;
    #1;
    checks++;
    if ({rx_done, d_out, frame_err, baud_tick} !== 11'b0 || u_dut.state !== IDLE) begin
      failures++; $display("FAIL midreset_outputs got done=%b d=%h fe=%b tick=%b state=%0d want 0", rx_done, d_out, frame_err, baud_tick, u_dut.state);
    end
    rx = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    drive(1'b1, 3 * BIT);
    checks++;
    if (got_q.size() != 0 || d_out !== 8'h00) begin
      failures++; $display("FAIL midreset_quiet got pulses=%0d d=%h want 0,00", got_q.size(), d_out);
    end
    send_frame(8'h81, 1'b1, t0);
    wait_done(100, ok, e);
    checks++;
    if (!ok || e.d !== 8'h81 || e.fe !== 1'b0) begin
      failures++; $display("FAIL midreset_next got ok=%b d=%h fe=%b want 81 fe=0", ok, e.d, e.fe);
    end
    last_byte = 8'h81;
  endtask

  task automatic test_random;
    int t0, gap; logic ok, stop_ok; ev_t e;
    logic [7:0] data;
    for (int k = 0; k < 8; k++) begin
      data    = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      gap     = int'($urandom_range(1, 2 * BIT));
      drive(1'b1, gap);
      send_frame(data, stop_ok, t0);
      if (!stop_ok) drive(1'b1, BIT);
      wait_done(100, ok, e);
      checks++;
      if (!ok || e.d !== data || e.fe !== !stop_ok) begin
        failures++; $display("FAIL random_frame%0d got ok=%b d=%h fe=%b want d=%h fe=%b", k, ok, e.d, e.fe, data, !stop_ok);
      end
      checks++;
      if (ok && (e.t - t0 < LAT_MIN || e.t - t0 > LAT_MAX)) begin
        failures++; $display("FAIL random_latency%0d got %0d want %0d..%0d", k, e.t - t0, LAT_MIN, LAT_MAX);
      end
    end
    drive(1'b1, 2 * BIT);
    checks++;
    if (got_q.size() != 0 || dbl_cnt != 0) begin
      failures++; $display("FAIL pulse_integrity got extra=%0d double=%0d want 0,0", got_q.size(), dbl_cnt);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clock);
    #1;
    test_tick_period();
    test_nominal();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial UART receiver: 8 data bits, LSB first, no parity, 1 stop bit, 16x oversampling.
- Contains its own baud-tick generator. It produces a one-clock strobe at 16x the baud rate from the system clock.
- Delivers each received byte on a parallel bus with a one-cycle done strobe.
- Sits between the board RX pin and the UART byte consumer (FIFO/command parser).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line baud rate.
- OVERSAMPLE, 16, ticks per bit period.
- DATA_BITS, 8, data bits per frame.
- STOP_TICKS, 16, ticks spent in the stop bit (16 = one stop bit).
- DIVISOR, round(CLK_FREQ/(BAUD*OVERSAMPLE)) = 326, clocks per tick.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  serial line; idles high; asynchronous to clock.
- rx_done  out  1  one-clock pulse when a frame completes.
- d_out  out  DATA_BITS  last received byte; held until the next completion.
- frame_err  out  1  stop-bit value of the last frame was 0; updated together with rx_done.
- baud_tick  out  1  16x baud strobe, one clock wide; for observation and sharing.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; tick counter, bit counter and shift register = 0.
  - d_out=0, rx_done=0, frame_err=0.
  - Baud counter=0, baud_tick=0.
  - Reset mid-frame abandons the frame with no rx_done.
- Baud generator:
  - Counter of width clog2(DIVISOR) runs 0..DIVISOR-1 and wraps to 0.
  - baud_tick=1 for exactly the clock where counter==DIVISOR-1. Period is DIVISOR clocks (326 at defaults).
  - Free-running; not synchronised to frame start.
- Input conditioning: rx passes through a 2-flop synchroniser (reset value 1). FSM uses only the synchronised value rxs. Start detection therefore lags the line by 2 clocks.
- Tick counter s (4 bits) counts baud_ticks within a state. Bit counter n counts 0..DATA_BITS-1.
- FSM:
  - IDLE: rxs==0 -> START with s=0. Level-sensitive: a line held low re-triggers.
  - START:
    - On baud_tick with s==7 (mid start bit): if rxs==0 -> DATA with s=0, n=0; else -> IDLE (glitch rejected, no outputs change).
    - Otherwise s increments on each tick.
  - DATA:
    - On baud_tick with s==15: sample rxs and shift right into the MSB (LSB-first reception), s=0.
    - If n==DATA_BITS-1 -> STOP, else n increments.
  - STOP:
    - On baud_tick with s==STOP_TICKS-1: d_out<=shift register, frame_err<=~rxs, rx_done=1 for this one clock, -> IDLE.
- Latency: rx_done asserts about 9.5 bit periods after the start-bit falling edge, within ±1 tick of jitter from the free-running generator.
- rx_done is never asserted for two consecutive clocks.
- Framing error: byte is still delivered and rx_done still pulses; frame_err=1.
- Back-to-back frames: a new start bit arriving right after the stop sampling point is caught from IDLE.
- Bit sampling points are all mid-bit, at tick offsets 8+16k from the start edge.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum {IDLE, START, DATA, STOP}.
  - Default constants CLK_FREQ, BAUD, OVERSAMPLE, DATA_BITS.
  - A function computing DIVISOR.
- One sub-module, uart_baud_tick_gen (parameter DIVISOR; ports clock, reset, tick). Instantiated inside uart_receiver, and reusable by a future transmitter.
- Synchroniser and FSM stay in the top module.

Test Plan:
- Tick period: after reset release, measure baud_tick spacing -> exactly 326 clocks apart, each pulse 1 clock wide.
- Nominal frame: drive idle high, then start 0, bits 1,1,1,0,1,0,1,0, stop 1, each 16 ticks (104.2 µs) -> one rx_done pulse; d_out=0x57; frame_err=0; d_out stays 0x57 afterwards.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done pulses about 10 bit-times apart; d_out=0x00, then 0xFF.
- Glitch: rx low for 4 ticks then high -> no rx_done; d_out unchanged; FSM back in IDLE; a following valid 0xA5 frame is received correctly.
- Framing error: frame 0x3C with stop bit 0 -> rx_done pulses; d_out=0x3C; frame_err=1. The next good frame clears frame_err to 0.
- Reset mid-frame: assert reset=0 during data bit 4 of a frame -> outputs immediately 0 and state IDLE. After release with rx idle high, no rx_done fires, then a new 0x81 frame is received correctly.
